posit_to_fp32_pipe: RTL and testbench

//  Converts the decoded field set of a posit<32,3> into an IEEE-754 binary32 word, with a 2-stage valid/ready pipeline.

---
 rtl/posit_fp_pkg.sv | 33 +++
 rtl/posit_rne_round.sv | 29 ++
 rtl/posit_to_fp32_pipe.sv | 155 +++++++++++++++
 tb/tb_posit_to_fp32_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_fp_pkg.sv
// Shared constants, the S1 register bundle and the biased-exponent helper for the
// posit<32,3> to binary32 converter.
package posit_fp_pkg;

    localparam int P_N  = 32;
    localparam int P_ES = 3;
    localparam int P_RS = 6;
    localparam int P_FS = P_N - 3 - P_ES;
    localparam int P_MW = P_FS + 1;
    localparam int P_EW = 10;

    localparam int          FP_BIAS = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    localparam logic [30:0] FP_MAXF = 31'h7F7FFFFF;

    typedef logic signed [P_EW-1:0] fp_exp_t;

    typedef struct packed {
        logic            sign;
        logic            zero;
        logic            nar;
        fp_exp_t         expo;
        logic [P_MW-1:0] mant;
    } s1_bundle_t;

    // 8*k + e + 127; ten signed bits cover every k/e pair the decoder can emit.
    function automatic fp_exp_t biased_exp(input logic [P_RS-1:0] k, input logic [P_ES-1:0] e);
        fp_exp_t w_k;
        w_k = {{(P_EW-P_RS){k[P_RS-1]}}, k};
        return (w_k <<< P_ES) + fp_exp_t'({{(P_EW-P_ES){1'b0}}, e}) + fp_exp_t'(FP_BIAS);
    endfunction

endpackage

// File: rtl/posit_rne_round.sv
// Round-to-nearest-even of a 27-bit mantissa (lead bit, 23 kept bits, guard, two sticky)
// to a 23-bit binary32 fraction field.
module posit_rne_round
    import posit_fp_pkg::*;
(
    input  logic [P_MW-1:0] i_mant,
    input  logic            i_sticky,
    output logic [22:0]     o_frac,
    output logic            o_carry,
    output logic            o_inex
);

    logic        w_guard;
    logic        w_sticky;
    logic        w_rup;
    logic [24:0] w_sum;

    assign w_guard  = i_mant[2];
    assign w_sticky = (|i_mant[1:0]) | i_sticky;
    assign w_rup    = w_guard & (w_sticky | i_mant[3]);
    assign w_sum    = {1'b0, i_mant[P_MW-1:3]} + {24'd0, w_rup};

    // Exponent field steps up when a normal mantissa overflows, or when a
    // subnormal one rounds up into the hidden-bit position.
    assign o_carry  = w_sum[24] | (w_sum[23] & ~i_mant[P_MW-1]);
    assign o_frac   = w_sum[22:0];
    assign o_inex   = w_guard | w_sticky;

endmodule

// File: rtl/posit_to_fp32_pipe.sv
// Two-stage valid/ready converter from decoded posit<32,3> fields to IEEE-754 binary32.
// Define SUBNORMAL_EN to produce gradual underflow; otherwise tiny results flush to signed zero.
module posit_to_fp32_pipe
    import posit_fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sign,
    input  logic [P_RS-1:0] in_regi,
    input  logic [P_ES-1:0] in_expo,
    input  logic [P_FS-1:0] in_frac,
    input  logic            in_zero,
    input  logic            in_nar,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_float,
    output logic            out_ovf,
    output logic            out_unf,
    output logic            out_inex
);

    s1_bundle_t      r_s1;
    logic            r_s1_valid;
    logic            r_out_valid;
    logic [31:0]     r_out_float;
    logic            r_out_ovf;
    logic            r_out_unf;
    logic            r_out_inex;

    s1_bundle_t      w_s1_next;
    logic            w_adv;
    logic            w_in_ready;
    logic            w_tiny;
    logic [P_MW-1:0] w_rnd_mant;
    logic            w_rnd_sticky;
    logic [22:0]     w_frac;
    logic            w_carry;
    logic            w_inex;
    fp_exp_t         w_exp_base;
    fp_exp_t         w_exp_r;
    logic [31:0]     w_float;
    logic            w_ovf;
    logic            w_unf;
    logic            w_inex_flag;

    assign w_adv      = !r_out_valid || out_ready;
    assign w_in_ready = w_adv || !r_s1_valid;

    always_comb begin
        w_s1_next      = '0;
        w_s1_next.sign = in_sign;
        w_s1_next.zero = in_zero;
        w_s1_next.nar  = in_nar;
        w_s1_next.expo = biased_exp(in_regi, in_expo);
        w_s1_next.mant = {1'b1, in_frac};
    end

    assign w_tiny = (r_s1.expo <= fp_exp_t'(0));

`ifdef SUBNORMAL_EN
    fp_exp_t           w_shamt;
    logic [4:0]        w_sh;
    logic [2*P_MW-1:0] w_wide;

    // Shifts of 27 or more leave nothing above the guard bit, so 31 is a safe clamp.
    assign w_shamt      = fp_exp_t'(1) - r_s1.expo;
    assign w_sh         = (w_shamt > fp_exp_t'(31)) ? 5'd31 : w_shamt[4:0];
    assign w_wide       = {r_s1.mant, {P_MW{1'b0}}} >> w_sh;
    assign w_rnd_mant   = w_tiny ? w_wide[2*P_MW-1:P_MW] : r_s1.mant;
    assign w_rnd_sticky = w_tiny & (|w_wide[P_MW-1:0]);
    assign w_exp_base   = w_tiny ? fp_exp_t'(0) : r_s1.expo;
`else
    assign w_rnd_mant   = r_s1.mant;
    assign w_rnd_sticky = 1'b0;
    assign w_exp_base   = r_s1.expo;
`endif

    posit_rne_round u_round (
        .i_mant   (w_rnd_mant),
        .i_sticky (w_rnd_sticky),
        .o_frac   (w_frac),
        .o_carry  (w_carry),
        .o_inex   (w_inex)
    );

    assign w_exp_r = w_exp_base + fp_exp_t'({{(P_EW-1){1'b0}}, w_carry});

    always_comb begin
        w_float     = '0;
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        w_inex_flag = 1'b0;
        if (r_s1.nar) begin
            w_float = FP_QNAN;
        end else if (r_s1.zero) begin
            w_float = '0;
        end else if (w_tiny) begin
`ifdef SUBNORMAL_EN
            w_float     = {r_s1.sign, w_exp_r[7:0], w_frac};
            w_unf       = (w_exp_r == fp_exp_t'(0));
            w_inex_flag = w_inex;
`else
            w_float     = {r_s1.sign, 31'd0};
            w_unf       = 1'b1;
            w_inex_flag = 1'b1;
`endif
        end else if (w_exp_r >= fp_exp_t'(255)) begin
            w_float     = {r_s1.sign, FP_MAXF};
            w_ovf       = 1'b1;
            w_inex_flag = w_inex;
        end else begin
            w_float     = {r_s1.sign, w_exp_r[7:0], w_frac};
            w_inex_flag = w_inex;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_out_valid <= 1'b0;
            r_out_float <= '0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
            r_out_inex  <= 1'b0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1 <= w_s1_next;
                end
            end
            // Output word and its flags only move when the consumer frees the slot.
            if (w_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_float <= w_float;
                    r_out_ovf   <= w_ovf;
                    r_out_unf   <= w_unf;
                    r_out_inex  <= w_inex_flag;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_float = r_out_float;
    assign out_ovf   = r_out_ovf;
    assign out_unf   = r_out_unf;
    assign out_inex  = r_out_inex;

endmodule

// File: tb/tb_posit_to_fp32_pipe.sv
// Self-checking bench for posit_to_fp32_pipe: value-level reference model, scoreboard and
// hold-stability monitor, hand-computed pins, backpressure, throughput and async reset.
module tb_posit_to_fp32_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [5:0]  in_regi;
    logic [2:0]  in_expo;
    logic [25:0] in_frac;
    logic        in_zero;
    logic        in_nar;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inex;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    logic [34:0] exp_q[$];
    logic        held_pending = 1'b0;
    logic [34:0] held_val;

    always #5 clk = ~clk;

    posit_to_fp32_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_regi   (in_regi),
        .in_expo   (in_expo),
        .in_frac   (in_frac),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_inex  (out_inex)
    );

    // Exact value M * 2^(E-153) rounded to the binary32 grid: ulp is 2^(max(E-127,-126)-23).
    // Returned as {float, ovf, unf, inex}.
    function automatic logic [34:0] model(input logic s, input int k, input int e, input int frac,
                                          input logic z, input logic nr);
        longint m_val, r_val, rem, half;
        int     ee, q, d, biased;
        logic   inex;
        if (nr) return {32'h7FC00000, 3'b000};
        if (z)  return 35'd0;
        ee = 8 * k + e + 127;
`ifndef SUBNORMAL_EN
        if (ee <= 0) return {s, 31'd0, 3'b011};
`endif
        m_val = longint'(frac) + (longint'(1) << 26);
        q = (((ee - 127) > -126) ? (ee - 127) : -126) - 23;
        d = q - (ee - 153);
        if (d > 60) begin
            r_val = 0;
            inex  = 1'b1;
        end else begin
            r_val = m_val >> d;
            rem   = m_val - (r_val << d);
            half  = longint'(1) << (d - 1);
            if (rem > half || (rem == half && r_val[0])) r_val = r_val + 1;
            inex = (rem != 0);
        end
        if (r_val == (longint'(1) << 24)) begin
            r_val = r_val >> 1;
            q     = q + 1;
        end
        biased = (r_val >= (longint'(1) << 23)) ? q + 150 : 0;
        if (biased >= 255) return {s, 31'h7F7FFFFF, 1'b1, 1'b0, inex};
        return {s, biased[7:0], r_val[22:0], 1'b0, (biased == 0), inex};
    endfunction

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got float=%h ovf/unf/inex=%b, required float=%h ovf/unf/inex=%b",
                     name, act[34:3], act[2:0], want[34:3], want[2:0]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare process: scoreboard on output transfers, stability while stalled, push on accepts.
    initial forever begin
        logic [34:0] word;
        @(negedge clk);
        word = {out_float, out_ovf, out_unf, out_inex};
        if (rst) begin
            exp_q.delete();
            held_pending = 1'b0;
        end else begin
            if (held_pending) begin
                chk("hold valid", 35'(out_valid), 35'd1);
                chk("hold word", word, held_val);
            end
            held_pending = out_valid && !out_ready;
            held_val     = word;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream: got unexpected word %h, required no word", out_float);
                end else begin
                    chk("stream", word, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sign, int'($signed(in_regi)), int'(in_expo),
                                      int'(in_frac), in_zero, in_nar));
        end
    end

    task automatic drive_one(input logic s, input int k, input int e, input int frac,
                             input logic z, input logic nr);
        bit ok;
        ok       = 1'b0;
        in_sign  = s;
        in_regi  = 6'(k);
        in_expo  = 3'(e);
        in_frac  = 26'(frac);
        in_zero  = z;
        in_nar   = nr;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept: in_ready got 0 for 200 cycles, required 1");
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pin(input string name, input logic s, input int k, input int e, input int frac,
                       input logic z, input logic nr, input logic [34:0] want);
        chk(name, model(s, k, e, frac, z, nr), want);
        drive_one(s, k, e, frac, z, nr);
    endtask

    task automatic rand_word();
        int k, e, frac, fsel;
        logic s, z, nr;
        case ($urandom_range(0, 3))
            0:       k = int'($urandom_range(0, 63)) - 32;
            1:       k = -17 + int'($urandom_range(0, 2));
            2:       k = 14 + int'($urandom_range(0, 2));
            default: k = int'($urandom_range(0, 6)) - 3;
        endcase
        e    = int'($urandom_range(0, 7));
        frac = int'($urandom_range(0, 26'h3FFFFFF));
        fsel = int'($urandom_range(0, 7));
        if (fsel == 0) frac = 26'h3FFFFFF;
        else if (fsel == 1) frac = (frac & ~7) | 4;
        s  = 1'($urandom_range(0, 1));
        z  = ($urandom_range(0, 15) == 0);
        nr = ($urandom_range(0, 15) == 0);
        drive_one(s, k, e, frac, z, nr);
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, 35'({exp_q.size() != 0, out_valid}), 35'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_regi  = '0;
        in_expo  = '0;
        in_frac  = '0;
        in_zero  = 1'b0;
        in_nar   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 35'(out_valid), 35'd0);
        chk("reset word", {out_float, out_ovf, out_unf, out_inex}, 35'd0);
        chk("reset in_ready", 35'(in_ready), 35'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: accepted at one edge, visible after the second edge.
        drive_one(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("latency stage1", 35'(out_valid), 35'd0);
        @(posedge clk);
        #1;
        chk("latency out_valid", 35'(out_valid), 35'd1);
        chk("latency word", {out_float, out_ovf, out_unf, out_inex}, {32'h3F800000, 3'b000});
        drain("drain latency");

        pin("one",           1'b0,   0, 0, 0,           1'b0, 1'b0, {32'h3F800000, 3'b000});
        pin("tie even",      1'b0,   0, 0, 4,           1'b0, 1'b0, {32'h3F800000, 3'b001});
        pin("round up",      1'b0,   0, 0, 6,           1'b0, 1'b0, {32'h3F800001, 3'b001});
        pin("neg normal",    1'b1,  -1, 4, 0,           1'b0, 1'b0, {32'hBD800000, 3'b000});
        pin("sat round",     1'b0,  15, 7, 26'h3FFFFFF, 1'b0, 1'b0, {32'h7F7FFFFF, 3'b101});
        pin("sat neg",       1'b1,  30, 0, 0,           1'b0, 1'b0, {32'hFF7FFFFF, 3'b100});
`ifdef SUBNORMAL_EN
        pin("underflow",     1'b0, -16, 0, 0,           1'b0, 1'b0, {32'h00200000, 3'b010});
        pin("min normal",    1'b0, -16, 1, 26'h3FFFFFF, 1'b0, 1'b0, {32'h00800000, 3'b001});
`else
        pin("underflow",     1'b0, -16, 0, 0,           1'b0, 1'b0, {32'h00000000, 3'b011});
        pin("min normal",    1'b0, -16, 1, 26'h3FFFFFF, 1'b0, 1'b0, {32'h00000000, 3'b011});
`endif
        pin("nar",           1'b1,  -5, 3, 12345,       1'b0, 1'b1, {32'h7FC00000, 3'b000});
        pin("zero",          1'b0,   0, 0, 0,           1'b1, 1'b0, 35'd0);
        pin("nar over zero", 1'b1,   0, 0, 0,           1'b1, 1'b1, {32'h7FC00000, 3'b000});
        drain("drain pins");

        set_mode(1);
        repeat (8) rand_word();
        drain("drain backpressure");

        set_mode(0);
        t0 = cyc;
        repeat (20) rand_word();
        chk("throughput cycles", 35'(cyc - t0), 35'd20);
        drain("drain throughput");

        set_mode(2);
        repeat (300) rand_word();
        set_mode(0);
        drain("drain random");

        // Fill both stages under a stalled consumer, then reset between edges.
        set_mode(3);
        rand_word();
        rand_word();
        @(posedge clk);
        #3;
        chk("pre-reset out_valid", 35'(out_valid), 35'd1);
        rst = 1'b1;
        #1;
        chk("async reset out_valid", 35'(out_valid), 35'd0);
        chk("async reset in_ready", 35'(in_ready), 35'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_mode(0);
        pin("restart", 1'b0, 0, 0, 6, 1'b0, 1'b0, {32'h3F800001, 3'b001});
        drain("drain restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
